// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer.
package pipe_ctrl_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STEP = 2'd2
  } pc_state_t;

  typedef struct packed {
    logic en;
    logic flush;
  } stage_ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the load in EX and the instruction in ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       memread,
  input  logic [4:0] ex_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  output logic       hazard
);

  logic match1;
  logic match2;

  // x0 is never a real producer, so it cannot cause a stall.
  always_comb begin
    match1 = use_rs1 && (rs1 == ex_rd);
    match2 = use_rs2 && (rs2 == ex_rd);
    hazard = memread && (ex_rd != 5'd0) && (match1 || match2);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: load-use stalls, redirect flushes, debug halt/step FSM, perf counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             Rst,
  input  logic             debug,
  input  logic             step,
  input  logic             cnt_clr,
  input  logic             ID_EX_memread,
  input  logic [4:0]       ID_EX_rd,
  input  logic [4:0]       IF_ID_rs1,
  input  logic [4:0]       IF_ID_rs2,
  input  logic             IF_ID_use_rs1,
  input  logic             IF_ID_use_rs2,
  input  logic             EX_redirect,
  output logic             pc_en,
  output logic             IF_ID_en,
  output logic             IF_ID_flush,
  output logic             ID_EX_en,
  output logic             ID_EX_flush,
  output logic             pipe_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pc_state_t   state;
  pc_state_t   state_nxt;
  stage_ctrl_t if_id_ctl;
  stage_ctrl_t id_ex_ctl;
  logic        hazard;
  logic        active;
  logic [1:0]  cnt_inc;
  logic [CNT_W-1:0] cnt [2];

  load_use_detect u_lud (
    .memread (ID_EX_memread),
    .ex_rd   (ID_EX_rd),
    .rs1     (IF_ID_rs1),
    .rs2     (IF_ID_rs2),
    .use_rs1 (IF_ID_use_rs1),
    .use_rs2 (IF_ID_use_rs2),
    .hazard  (hazard)
  );

  always_ff @(posedge clk) begin
    if (Rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Dropping debug in HALT wins over a concurrent step.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     state_nxt = debug ? HALT : RUN;
      HALT: begin
        if (!debug) begin
          state_nxt = RUN;
        end else if (step) begin
          state_nxt = STEP;
        end else begin
          state_nxt = HALT;
        end
      end
      STEP:    state_nxt = debug ? HALT : RUN;
      default: state_nxt = RUN;
    endcase
  end

  assign active = (state != HALT);
  assign halted = (state == HALT);

  // Priority: reset fill > halt freeze > redirect squash > load-use bubble.
  always_comb begin
    pc_en           = 1'b1;
    if_id_ctl       = '{en: 1'b1, flush: 1'b0};
    id_ex_ctl       = '{en: 1'b1, flush: 1'b0};
    pipe_en         = 1'b1;
    if (Rst) begin
      pc_en         = 1'b0;
      if_id_ctl     = '{en: 1'b0, flush: 1'b1};
      id_ex_ctl     = '{en: 1'b0, flush: 1'b1};
      pipe_en       = 1'b0;
    end else if (!active) begin
      pc_en         = 1'b0;
      if_id_ctl     = '{en: 1'b0, flush: 1'b0};
      id_ex_ctl     = '{en: 1'b0, flush: 1'b0};
      pipe_en       = 1'b0;
    end else if (EX_redirect) begin
      if_id_ctl.flush = 1'b1;
      id_ex_ctl.flush = 1'b1;
    end else if (hazard) begin
      pc_en           = 1'b0;
      if_id_ctl.en    = 1'b0;
      id_ex_ctl.flush = 1'b1;
    end else begin
      pc_en           = 1'b1;
    end
  end

  assign IF_ID_en    = if_id_ctl.en;
  assign IF_ID_flush = if_id_ctl.flush;
  assign ID_EX_en    = id_ex_ctl.en;
  assign ID_EX_flush = id_ex_ctl.flush;

  assign cnt_inc[0] = active && hazard && !EX_redirect;
  assign cnt_inc[1] = active && EX_redirect;

  for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
    // Saturating counter; clear beats increment.
    always_ff @(posedge clk) begin
      if (Rst || cnt_clr) begin
        cnt[gi] <= {CNT_W{1'b0}};
      end else if (cnt_inc[gi] && (cnt[gi] != {CNT_W{1'b1}})) begin
        cnt[gi] <= cnt[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt[gi] <= cnt[gi];
      end
    end
  end

  assign stall_cnt = cnt[0];
  assign flush_cnt = cnt[1];

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline sequencer for the five-stage Mini-RISC-V core. Generates per-stage enable and flush controls for the PC, IF/ID, ID/EX and EX/MEM-onward registers, so Execute and its neighbours no longer gate on `debug` individually. Owns three jobs:
- load-use hazard stalls (one bubble);
- taken-branch/jump redirect flushes;
- a debug halt / single-step state machine.

Keeps saturating stall and flush counters for performance debug.

## Interface
Parameters:
- `CNT_W`, default 16: width of the `stall_cnt` and `flush_cnt` counters.

Ports:
- `clk`: input, 1 bit. System clock.
- `Rst`: input, 1 bit. Reset, synchronous, active-high.
- `debug`: input, 1 bit. Level. Halt request.
- `step`: input, 1 bit. One-cycle pulse. Executes one pipeline advance while halted.
- `cnt_clr`: input, 1 bit. Synchronous clear of both counters.
- `ID_EX_memread`: input, 1 bit. The instruction in EX is a load.
- `ID_EX_rd`: input, 5 bits. Destination register of the instruction in EX.
- `IF_ID_rs1`, `IF_ID_rs2`: input, 5 bits each. Source registers of the instruction in ID.
- `IF_ID_use_rs1`, `IF_ID_use_rs2`: input, 1 bit each. The instruction in ID actually reads that source.
- `EX_redirect`: input, 1 bit. EX has resolved a taken branch, `jal` or `jalr`; PC loads the target this cycle.
- `pc_en`: output, 1 bit. PC register update enable.
- `IF_ID_en`: output, 1 bit. IF/ID register update enable.
- `IF_ID_flush`: output, 1 bit. Load a NOP into IF/ID.
- `ID_EX_en`: output, 1 bit. ID/EX register update enable.
- `ID_EX_flush`: output, 1 bit. Load a bubble into ID/EX; all control bits are 0.
- `pipe_en`: output, 1 bit. Update enable for EX/MEM, MEM/WB and WB/ID.
- `halted`: output, 1 bit. High while the state is HALT.
- `stall_cnt`: output, `CNT_W` bits. Count of load-use stall cycles.
- `flush_cnt`: output, `CNT_W` bits. Count of redirect cycles.

## Operation
State machine:
- States: RUN, HALT, STEP. Reset state is RUN.
- RUN → HALT when `debug`=1.
- HALT → STEP when `step`=1 and `debug`=1.
- HALT → RUN when `debug`=0. This takes priority over `step`.
- STEP → HALT when `debug`=1, otherwise STEP → RUN.
- STEP lasts exactly one cycle.

Freeze (state HALT):
- `pc_en`, `IF_ID_en`, `ID_EX_en` and `pipe_en` are 0.
- Both flushes are 0.
- Counters hold.

Active states (RUN or STEP):
- Defaults: all enables are 1 and both flushes are 0.
- Load-use hazard: `ID_EX_memread` and `ID_EX_rd`≠0 and ((`IF_ID_use_rs1` and `IF_ID_rs1`==`ID_EX_rd`) or (`IF_ID_use_rs2` and `IF_ID_rs2`==`ID_EX_rd`)).
  - On a hazard: `pc_en`=0, `IF_ID_en`=0, `ID_EX_flush`=1 (`ID_EX_en` stays 1).
  - `pipe_en`=1, so the load proceeds.
- Redirect (`EX_redirect`=1):
  - `IF_ID_flush`=1 and `ID_EX_flush`=1.
  - `pc_en`=1 and `IF_ID_en`=1.
  - Redirect takes priority over load-use: the stalled instruction in ID is squashed anyway, and no stall is counted.
- Flushes override enables: a register with both asserted loads the NOP/bubble.

Counters:
- `stall_cnt` increments in each active cycle with a load-use stall that is not overridden by a redirect.
- `flush_cnt` increments in each active cycle with `EX_redirect`=1.
- Both saturate at 2^`CNT_W`−1; no wrap.
- `cnt_clr` forces both to 0 and wins over an increment in the same cycle.
- `Rst` also clears both.

## Timing
- All enable and flush outputs are combinational from the current state and the same-cycle inputs, with zero latency.
- The state register and counters update on `posedge clk`.
- Latency of `debug`:
  - A rise in RUN allows that cycle to complete as RUN; the freeze starts the next cycle.
  - A fall in HALT freezes the current cycle; RUN resumes the next cycle.
- `step` is ignored outside HALT. A step that is held high for several cycles gives one advance per HALT→STEP→HALT round trip, i.e. every other cycle.
- A load-use bubble lasts one cycle. The next cycle sees `ID_EX_memread`=0, so the stall self-clears.
- A load-use hazard in STEP: the single step consumes the bubble cycle, and no instruction leaves ID.
- Reset values:
  - State is RUN and `halted`=0.
  - Counters are 0.
  - While `Rst`=1, all enables are 0 and both flushes are 1, so the pipe fills with NOPs.
- `Rst` asserted mid-step or mid-stall overrides everything and takes effect on the next edge.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - the state enum `pc_state_t` {RUN, HALT, STEP};
  - the `CNT_W` default constant;
  - the struct `stage_ctrl_t` bundling en/flush.
- Sub-module `load_use_detect`: purely combinational hazard compare (rd≠0 check, use-qualified rs match). Shared later with the compressed-decode path.
- Top level holds the FSM, the priority mux and two instances of a saturating-counter generate block.

## Test plan
- Load-use: EX has `lw` x5 (memread=1, rd=5); ID has `add` x6,x5,x1 (rs1=5, use_rs1=1).
  - Expect `pc_en`=0, `IF_ID_en`=0, `ID_EX_flush`=1 for exactly 1 cycle, then all enables are 1.
  - `stall_cnt` goes 0→1.
- x0 exemption:
  - `lw` x0 with ID rs1=0: no stall, counters unchanged.
  - Match on rs2 with use_rs2=0: no stall.
- Redirect with a simultaneous hazard: `EX_redirect`=1 plus the load-use condition.
  - Expect `IF_ID_flush`=1, `ID_EX_flush`=1, `pc_en`=1.
  - `flush_cnt`=1, `stall_cnt`=0.
- Debug halt and steps: in RUN, raise `debug` at cycle 10.
  - `halted`=1 from cycle 11 with all enables 0.
  - `step` pulses at cycles 15 and 16 give one STEP cycle at 16, the second pulse being ignored in STEP. `pipe_en`=1 only in cycle 16.
  - Drop `debug` at cycle 20: RUN from cycle 21.
- Saturation and clear:
  - Preload via 65535 stall cycles: `stall_cnt` holds at 16'hFFFF on further stalls.
  - `cnt_clr` together with a stall → 0.
- Reset mid-operation: assert `Rst` while in STEP.
  - Same cycle: flushes are 1 and enables are 0.
  - After the edge: RUN, `halted`=0, both counters 0.
